// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction table.
// Holds the counter type, controller state enum and counter limits.
package bp_pkg;

    typedef logic [1:0] cnt_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam cnt_t CNT_MAX = 2'd3;
    localparam cnt_t CNT_MIN = 2'd0;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-value logic.
// Ports: cnt (current), taken (direction), next_cnt (updated value).
module bp_sat_counter
    import bp_pkg::*;
(
    input  cnt_t cnt,
    input  logic taken,
    output cnt_t next_cnt
);

    always_comb begin
        next_cnt = cnt;
        if (taken) begin
            if (cnt != CNT_MAX) next_cnt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_MIN) next_cnt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_table_ctrl.sv
// Fully associative branch target table with 2-bit counters.
// Ports: IF_* lookup, EX_* resolve/update, Flush starts a clear sweep
// reported on Busy; CLK rising edge, RST_N async active-low.
module branch_predict_table_ctrl
    import bp_pkg::*;
#(
    parameter int   ENTRIES   = 8,
    parameter int   PC_W      = 32,
    parameter cnt_t CNT_ALLOC = 2'd3
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [PC_W-1:0] IF_PC,
    output logic            IF_Hit,
    output logic            IF_JumpPredict,
    output logic [PC_W-1:0] IF_Target,
    input  logic            EX_Valid,
    input  logic [PC_W-1:0] EX_PC,
    input  logic            EX_Success,
    input  logic [PC_W-1:0] EX_Target,
    input  logic            Flush,
    output logic            Busy
);

    localparam int IW = $clog2(ENTRIES);
    localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [ENTRIES-1:0] r_valid;
    logic [PC_W-1:0]    r_tag [ENTRIES];
    logic [PC_W-1:0]    r_tgt [ENTRIES];
    cnt_t               r_cnt [ENTRIES];
    logic [IW-1:0]      r_rr;
    logic [IW-1:0]      r_sidx;

    logic          w_if_hit;
    logic [IW-1:0] w_if_idx;
    logic          w_ex_hit;
    logic [IW-1:0] w_ex_idx;
    logic          w_any_inv;
    logic [IW-1:0] w_vic;
    logic          w_ex_en;
    logic          w_upd;
    logic          w_alloc;
    logic          w_sweep_done;
    cnt_t          w_cnt_nxt;

    // Tags are unique, so at most one entry can match either port.
    always_comb begin
        w_if_hit = 1'b0;
        w_if_idx = '0;
        w_ex_hit = 1'b0;
        w_ex_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && r_tag[i] == IF_PC) begin
                w_if_hit = 1'b1;
                w_if_idx = IW'(i);
            end
            if (r_valid[i] && r_tag[i] == EX_PC) begin
                w_ex_hit = 1'b1;
                w_ex_idx = IW'(i);
            end
        end
    end

    // Descending scan leaves the lowest free slot selected.
    always_comb begin
        w_any_inv = 1'b0;
        w_vic     = r_rr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_any_inv = 1'b1;
                w_vic     = IW'(i);
            end
        end
    end

    bp_sat_counter u_cnt (
        .cnt      (r_cnt[w_ex_idx]),
        .taken    (EX_Success),
        .next_cnt (w_cnt_nxt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (Flush) w_state_nxt = SWEEP;
            SWEEP:   if (!Flush && r_sidx == LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Flush has priority over any EX update in the same cycle.
    always_comb begin
        Busy         = (r_state == SWEEP);
        w_ex_en      = (r_state == IDLE) && !Flush && EX_Valid;
        w_sweep_done = Busy && !Flush && (r_sidx == LAST);
    end

    assign w_upd   = w_ex_en && w_ex_hit;
    assign w_alloc = w_ex_en && !w_ex_hit && EX_Success;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= '0;
            r_rr    <= '0;
            r_sidx  <= '0;
        end else if (Busy) begin
            r_valid[r_sidx] <= 1'b0;
            r_sidx <= Flush ? '0 : r_sidx + IW'(1);
            if (w_sweep_done) r_rr <= '0;
        end else if (Flush) begin
            r_sidx <= '0;
        end else if (w_alloc) begin
            r_valid[w_vic] <= 1'b1;
            if (!w_any_inv) r_rr <= r_rr + IW'(1);
        end
    end

    // Payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_upd) begin
            r_cnt[w_ex_idx] <= w_cnt_nxt;
            if (EX_Success) r_tgt[w_ex_idx] <= EX_Target;
        end else if (w_alloc) begin
            r_tag[w_vic] <= EX_PC;
            r_tgt[w_vic] <= EX_Target;
            r_cnt[w_vic] <= CNT_ALLOC;
        end
    end

    always_comb begin
        IF_Hit         = w_if_hit && !Busy;
        IF_JumpPredict = IF_Hit && r_cnt[w_if_idx][1];
        IF_Target      = IF_Hit ? r_tgt[w_if_idx] : '0;
    end

endmodule

// File: tb/tb_branch_predict_table_ctrl.sv
// Self-checking bench for branch_predict_table_ctrl.
// Directed scenarios plus random traffic against a table model.
module tb_branch_predict_table_ctrl;

    localparam int N = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_hit;
    logic        if_jp;
    logic [31:0] if_tgt;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_succ;
    logic [31:0] ex_tgt;
    logic        flush;
    logic        busy;

    int checks;
    int errors;

    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];
    int          m_rr;
    int          m_sidx;
    bit          m_busy;

    branch_predict_table_ctrl #(
        .ENTRIES   (N),
        .PC_W      (32),
        .CNT_ALLOC (2'd3)
    ) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .IF_PC          (if_pc),
        .IF_Hit         (if_hit),
        .IF_JumpPredict (if_jp),
        .IF_Target      (if_tgt),
        .EX_Valid       (ex_valid),
        .EX_PC          (ex_pc),
        .EX_Success     (ex_succ),
        .EX_Target      (ex_tgt),
        .Flush          (flush),
        .Busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_rr   = 0;
        m_sidx = 0;
        m_busy = 1'b0;
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    function automatic void m_edge();
        int k;
        int v;
        if (m_busy) begin
            if (flush) m_sidx = 0;
            else begin
                m_valid[m_sidx] = 1'b0;
                if (m_sidx == N - 1) begin
                    m_busy = 1'b0;
                    m_rr   = 0;
                    m_sidx = 0;
                end else m_sidx++;
            end
        end else if (flush) begin
            m_busy = 1'b1;
            m_sidx = 0;
        end else if (ex_valid) begin
            k = m_find(ex_pc);
            if (k >= 0) begin
                if (ex_succ) begin
                    m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
                    m_tgt[k] = ex_tgt;
                end else begin
                    m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
                end
            end else if (ex_succ) begin
                v = -1;
                for (int i = 0; i < N; i++)
                    if (!m_valid[i] && v < 0) v = i;
                if (v < 0) begin
                    v    = m_rr;
                    m_rr = (m_rr + 1) % N;
                end
                m_valid[v] = 1'b1;
                m_tag[v]   = ex_pc;
                m_tgt[v]   = ex_tgt;
                m_cnt[v]   = 3;
            end
        end
    endfunction

    task automatic m_expect(output logic h, output logic jp,
                            output logic [31:0] t);
        int k;
        k  = m_busy ? -1 : m_find(if_pc);
        h  = (k >= 0);
        jp = (k >= 0) ? (m_cnt[k] >= 2) : 1'b0;
        t  = (k >= 0) ? m_tgt[k] : 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
    endtask

    task automatic quiet();
        ex_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        quiet();
        #2;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [31:0] t);
        ex_valid = 1'b1;
        ex_pc    = pc;
        ex_succ  = 1'b1;
        ex_tgt   = t;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic s,
                           input logic [31:0] t);
        ex_valid = 1'b1;
        ex_pc    = pc;
        ex_succ  = s;
        ex_tgt   = t;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        quiet();
        if_pc = 32'h0;
        ex_pc = 32'h0;
        ex_succ = 1'b0;
        ex_tgt = 32'h0;
        #2;
        m_reset();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %0b want 0", busy);
        end
        checks++;
        if (if_hit !== 1'b0 || if_jp !== 1'b0 || if_tgt !== 32'h0) begin
            errors++;
            $display("FAIL reset_outs got %0b/%0b/%h want 0/0/0",
                     if_hit, if_jp, if_tgt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        alloc(32'h40, 32'h80);
        if_pc = 32'h40;
        #1;
        checks++;
        if (if_hit !== 1'b1 || if_jp !== 1'b1 || if_tgt !== 32'h80) begin
            errors++;
            $display("FAIL basic_lookup got %0b/%0b/%h want 1/1/00000080",
                     if_hit, if_jp, if_tgt);
        end
    endtask

    task automatic test_counter();
        logic exp_jp [4];
        exp_jp = '{1'b1, 1'b0, 1'b0, 1'b0};
        if_pc  = 32'h40;
        for (int i = 0; i < 4; i++) begin
            resolve(32'h40, 1'b0, 32'hDEAD);
            #1;
            checks++;
            if (if_jp !== exp_jp[i] || if_tgt !== 32'h80) begin
                errors++;
                $display("FAIL counter_down%0d got %0b/%h want %0b/00000080",
                         i, if_jp, if_tgt, exp_jp[i]);
            end
        end
        resolve(32'h40, 1'b1, 32'h90);
        #1;
        checks++;
        if (if_hit !== 1'b1 || if_jp !== 1'b0 || if_tgt !== 32'h90) begin
            errors++;
            $display("FAIL counter_up got %0b/%0b/%h want 1/0/00000090",
                     if_hit, if_jp, if_tgt);
        end
    endtask

    task automatic test_replace();
        do_reset();
        for (int i = 0; i < 9; i++)
            alloc(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i));
        if_pc = 32'h1000;
        #1;
        checks++;
        if (if_hit !== 1'b0) begin
            errors++;
            $display("FAIL replace_first got hit %0b want 0", if_hit);
        end
        if_pc = 32'h1020;
        #1;
        checks++;
        if (if_hit !== 1'b1 || if_tgt !== 32'h2008) begin
            errors++;
            $display("FAIL replace_ninth got %0b/%h want 1/00002008",
                     if_hit, if_tgt);
        end
        alloc(32'h1024, 32'h2009);
        if_pc = 32'h1004;
        #1;
        checks++;
        if (if_hit !== 1'b0) begin
            errors++;
            $display("FAIL replace_rr1 got hit %0b want 0", if_hit);
        end
        if_pc = 32'h1008;
        #1;
        checks++;
        if (if_hit !== 1'b1 || if_tgt !== 32'h2002) begin
            errors++;
            $display("FAIL replace_keep got %0b/%h want 1/00002002",
                     if_hit, if_tgt);
        end
    endtask

    task automatic test_same_cycle();
        alloc(32'h500, 32'h600);
        resolve(32'h500, 1'b0, 32'h0);
        resolve(32'h500, 1'b0, 32'h0);
        ex_valid = 1'b1;
        ex_pc    = 32'h500;
        ex_succ  = 1'b1;
        ex_tgt   = 32'h600;
        if_pc    = 32'h500;
        #1;
        checks++;
        if (if_hit !== 1'b1 || if_jp !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_pre got %0b/%0b want 1/0",
                     if_hit, if_jp);
        end
        tick();
        ex_valid = 1'b0;
        #1;
        checks++;
        if (if_jp !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_post got %0b want 1", if_jp);
        end
    endtask

    task automatic test_flush();
        int n;
        int masked;
        flush    = 1'b1;
        ex_valid = 1'b1;
        ex_pc    = 32'h7770;
        ex_succ  = 1'b1;
        ex_tgt   = 32'h1;
        if_pc    = 32'h500;
        tick();
        flush  = 1'b0;
        n      = 0;
        masked = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (if_hit !== 1'b0) masked++;
            tick();
        end
        ex_valid = 1'b0;
        checks++;
        if (n != 8 || masked != 0) begin
            errors++;
            $display("FAIL flush_busy got %0d cycles %0d hits want 8/0",
                     n, masked);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pcs [3];
            pcs = '{32'h7770, 32'h500, 32'h1020};
            if_pc = pcs[i];
            #1;
            checks++;
            if (if_hit !== 1'b0) begin
                errors++;
                $display("FAIL flush_miss%0d got hit %0b want 0", i, if_hit);
            end
        end
        alloc(32'h300, 32'h301);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL flush_restart got %0d cycles want 8", n);
        end
    endtask

    task automatic test_reset_mid_sweep();
        alloc(32'hA00, 32'hB00);
        alloc(32'hA04, 32'hB04);
        alloc(32'hA08, 32'hB08);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        if_pc = 32'hA08;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || if_hit !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_reset got busy %0b hit %0b want 0/0",
                     busy, if_hit);
        end
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || if_hit !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_release got busy %0b hit %0b want 0/0",
                     busy, if_hit);
        end
        for (int i = 0; i < 9; i++)
            alloc(32'hC00 + 32'(i * 4), 32'hD00 + 32'(i));
        if_pc = 32'hC00;
        #1;
        checks++;
        if (if_hit !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_rr got hit %0b want 0", if_hit);
        end
        if_pc = 32'hC04;
        #1;
        checks++;
        if (if_hit !== 1'b1 || if_tgt !== 32'hD01) begin
            errors++;
            $display("FAIL midsweep_keep got %0b/%h want 1/00000d01",
                     if_hit, if_tgt);
        end
    endtask

    task automatic test_random();
        logic        eh;
        logic        ej;
        logic [31:0] et;
        for (int c = 0; c < 800; c++) begin
            flush    = ($urandom_range(0, 39) == 0);
            ex_valid = $urandom_range(0, 1) == 1;
            ex_pc    = 32'h100 + 32'($urandom_range(0, 11) * 4);
            ex_succ  = $urandom_range(0, 2) != 0;
            ex_tgt   = $urandom;
            if_pc    = 32'h100 + 32'($urandom_range(0, 11) * 4);
            #1;
            m_expect(eh, ej, et);
            checks++;
            if (if_hit !== eh || if_jp !== ej || if_tgt !== et ||
                busy !== m_busy) begin
                errors++;
                $display("FAIL random_c%0d got %0b/%0b/%h/%0b want %0b/%0b/%h/%0b",
                         c, if_hit, if_jp, if_tgt, busy, eh, ej, et, m_busy);
            end
            tick();
        end
        quiet();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_counter();
        test_replace();
        test_same_cycle();
        test_flush();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
